// File: rtl/luna_pkg.sv
// Shared definitions for the Luna sequencer: state encoding and reset PC.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package luna_pkg;

  typedef enum logic [2:0] {
    FETCH   = 3'd0,
    DECODE  = 3'd1,
    EXECUTE = 3'd2,
    STORE   = 3'd3,
    HALT    = 3'd4
  } state_t;

  localparam logic [15:0] LUNA_RESET_PC = 16'h0000;

endpackage

// File: rtl/program_counter.sv
// Program counter register with load and increment controls.
// Latency: new value visible one cycle after load/inc is sampled.
// Backpressure: none; load takes priority over inc, increment wraps modulo 2^ADDR_W.
module program_counter
  import luna_pkg::*;
#(
  parameter int unsigned           ADDR_W   = 16,
  parameter logic [ADDR_W-1:0]     RESET_PC = ADDR_W'(LUNA_RESET_PC)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              inc,
  input  logic [ADDR_W-1:0] load_value,
  output logic [ADDR_W-1:0] pc
);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;

  // Next PC: a jump load wins over the sequential increment.
  always_comb begin
    pc_d = pc_q;
    if (load) begin
      pc_d = load_value;
    end else if (inc) begin
      pc_d = pc_q + ADDR_W'(1);
    end
  end

  // PC register, reset straight to the boot address.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle FETCH/DECODE/EXECUTE/STORE sequencer owning PC and IR; optional LUNA_SINGLE_STEP_EN adds a step input.
// Latency: 4 cycles per instruction with a first-cycle ack, +1 per fetch wait cycle.
// Backpressure: holds imem_req/imem_addr in FETCH until imem_ack; halt parks the block in HALT after STORE.
module cpu_sequencer
  import luna_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 16,
  parameter int unsigned       INSTR_W  = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(LUNA_RESET_PC)
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  pc,
  input  logic               set_pc,
  input  logic [ADDR_W-1:0]  jump_target,
  input  logic               a_en_in,
  input  logic               d_en_in,
  input  logic               m_en_in,
  output logic               a_we,
  output logic               d_we,
  output logic               m_we,
  input  logic               halt,
`ifdef LUNA_SINGLE_STEP_EN
  input  logic               step,
`endif
  output logic               halted,
  output logic               retire
);

  state_t             state_q, state_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               req_q, req_d;
  logic               a_we_q, a_we_d;
  logic               d_we_q, d_we_d;
  logic               m_we_q, m_we_d;
  logic               retire_q, retire_d;
  logic               halted_q, halted_d;
  logic               pc_load;
  logic               pc_inc;

  program_counter #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_program_counter (
    .clk        (clk),
    .rst        (rst),
    .load       (pc_load),
    .inc        (pc_inc),
    .load_value (jump_target),
    .pc         (pc)
  );

  // Next state, IR capture and PC update; registered outputs are derived from the next state.
  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    req_d   = 1'b0;
    pc_load = 1'b0;
    pc_inc  = 1'b0;
    case (state_q)
      FETCH: begin
        // The first FETCH cycle after reset has req low, so a stale ack is never taken.
        if (req_q && imem_ack) begin
          instr_d = imem_rdata;
          state_d = DECODE;
        end else begin
          req_d = 1'b1;
        end
      end
      DECODE:  state_d = EXECUTE;
      EXECUTE: state_d = STORE;
      STORE: begin
        pc_load = set_pc;
        pc_inc  = !set_pc;
`ifdef LUNA_SINGLE_STEP_EN
        state_d = HALT;
`else
        state_d = halt ? HALT : FETCH;
`endif
        req_d   = (state_d == FETCH);
      end
      HALT: begin
`ifdef LUNA_SINGLE_STEP_EN
        if (step) begin
`else
        if (!halt) begin
`endif
          state_d = FETCH;
          req_d   = 1'b1;
        end
      end
      default: state_d = FETCH;
    endcase
    retire_d = (state_d == STORE);
    a_we_d   = (state_d == STORE) && a_en_in;
    d_we_d   = (state_d == STORE) && d_en_in;
    m_we_d   = (state_d == STORE) && m_en_in;
    halted_d = (state_d == HALT);
  end

  // State, IR and registered output strobes; reset abandons any fetch in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= FETCH;
      instr_q  <= '0;
      req_q    <= 1'b0;
      a_we_q   <= 1'b0;
      d_we_q   <= 1'b0;
      m_we_q   <= 1'b0;
      retire_q <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      instr_q  <= instr_d;
      req_q    <= req_d;
      a_we_q   <= a_we_d;
      d_we_q   <= d_we_d;
      m_we_q   <= m_we_d;
      retire_q <= retire_d;
      halted_q <= halted_d;
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = pc;
  assign instr     = instr_q;
  assign a_we      = a_we_q;
  assign d_we      = d_we_q;
  assign m_we      = m_we_q;
  assign retire    = retire_q;
  assign halted    = halted_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Scoreboard bench for cpu_sequencer: randomized imem/control-unit stimulus vs. an instruction-level model.
// Latency: n/a.
// Backpressure: bench acts as instruction memory with random ack delays.
module tb_cpu_sequencer;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic [15:0] instr;
  logic [15:0] pc;
  logic        set_pc;
  logic [15:0] jump_target;
  logic        a_en_in, d_en_in, m_en_in;
  logic        a_we, d_we, m_we;
  logic        halt;
  logic        halted;
  logic        retire;

  cpu_sequencer #(
    .ADDR_W   (16),
    .INSTR_W  (16),
    .RESET_PC (16'h0000)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .pc          (pc),
    .set_pc      (set_pc),
    .jump_target (jump_target),
    .a_en_in     (a_en_in),
    .d_en_in     (d_en_in),
    .m_en_in     (m_en_in),
    .a_we        (a_we),
    .d_we        (d_we),
    .m_we        (m_we),
    .halt        (halt),
    .halted      (halted),
    .retire      (retire)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] pc;
    logic [15:0] ins;
    logic        a, d, m;
    logic        hlt;
    int          lat;
  } rec_t;

  rec_t        sb[$];
  logic [15:0] model_pc;
  int          errors;
  int          checks;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic noise();
    a_en_in     = 1'($urandom);
    d_en_in     = 1'($urandom);
    m_en_in     = 1'($urandom);
    set_pc      = 1'($urandom);
    jump_target = 16'($urandom);
    imem_rdata  = 16'($urandom);
  endtask

  // Called on a negedge; returns on the negedge where the block is back in FETCH.
  // mode: 0 plain, 1 random, 2 jump to 00A0, 3 jump to FFFF, 4 halt asserted from EXECUTE.
  task automatic run_instr(input int d, input int mode);
    rec_t        r;
    logic        hv, sp;
    logic [15:0] tgt, ins;
    int          n, k;
    n = 0;
    while (!imem_req && n < 50) begin
      imem_ack = 1'b0;
      imem_rdata = 16'($urandom);
      @(negedge clk);
      n++;
    end
    chk("fetch_req_seen", imem_req, 1);
    for (int i = 0; i < d; i++) begin
      imem_ack = 1'b0;
      noise();
      halt = 1'($urandom);
      @(negedge clk);
    end
    ins = (mode == 0 || mode == 4) ? 16'h1234 : 16'($urandom);
    sp  = 1'b0;
    tgt = 16'($urandom);
    hv  = 1'b0;
    case (mode)
      1: begin
        sp = ($urandom_range(0, 3) == 0);
        if ($urandom_range(0, 2) == 0) tgt = 16'hFFFF;
        hv = ($urandom_range(0, 4) == 0);
      end
      2: begin sp = 1'b1; tgt = 16'h00A0; end
      3: begin sp = 1'b1; tgt = 16'hFFFF; end
      4: hv = 1'b1;
      default: ;
    endcase
    imem_ack    = 1'b1;
    imem_rdata  = ins;
    set_pc      = sp;
    jump_target = tgt;
    a_en_in     = (mode == 0) ? 1'b1 : 1'($urandom);
    d_en_in     = (mode == 0) ? 1'b1 : 1'($urandom);
    m_en_in     = (mode == 0) ? 1'b1 : 1'($urandom);
    halt        = 1'($urandom);
    r.pc = model_pc; r.ins = ins; r.a = a_en_in; r.d = d_en_in; r.m = m_en_in;
    r.hlt = hv; r.lat = 3 + d;
    sb.push_back(r);
    @(negedge clk);                       // DECODE
    imem_ack   = 1'b0;
    imem_rdata = 16'($urandom);
    halt       = (mode == 4) ? 1'b0 : 1'($urandom);
    @(negedge clk);                       // EXECUTE
    halt       = (mode == 4) ? 1'b1 : 1'($urandom);
    @(negedge clk);                       // STORE
    halt       = hv;
    model_pc   = sp ? tgt : model_pc + 16'd1;
    @(negedge clk);                       // FETCH or HALT
    noise();
    if (hv) begin
      k = $urandom_range(0, 2);
      halt = 1'b1;
      repeat (k) @(negedge clk);
      halt = 1'b0;
      @(negedge clk);
    end else begin
      halt = 1'($urandom);
    end
  endtask

  // Monitor: protocol properties every cycle, scoreboard pop on each retire.
  initial begin
    rec_t        r;
    int          t, rise_t;
    logic        prev_req, prev_ret, prev_rst, prev_halted, chk_next, next_halt;
    logic [15:0] prev_addr;
    t = 0; rise_t = 0;
    prev_req = 1'b0; prev_ret = 1'b0; prev_rst = 1'b0; prev_halted = 1'b0;
    chk_next = 1'b0; next_halt = 1'b0; prev_addr = '0;
    forever begin
      @(posedge clk);
      #1;
      t++;
      if (rst && !prev_req && imem_req) rise_t = t;
      if (rst && prev_rst) begin
        if (chk_next) begin
          chk("halted_after_store", halted, next_halt);
          chk("req_after_store", imem_req, !next_halt);
        end
        if (prev_req && imem_ack) chk("req_drop_after_ack", imem_req, 0);
        if (prev_req && !imem_ack) begin
          chk("req_held", imem_req, 1);
          chk("addr_stable", imem_addr, prev_addr);
        end
        if (prev_halted && !halted) chk("req_on_halt_exit", imem_req, 1);
        if (!retire) chk("we_outside_store", {a_we, d_we, m_we}, 0);
        chk_next = 1'b0;
        if (retire) begin
          chk("retire_one_cycle", prev_ret, 0);
          if (sb.size() == 0) begin
            chk("retire_without_fetch", retire, 0);
          end else begin
            r = sb.pop_front();
            chk("store_pc", pc, r.pc);
            chk("store_instr", instr, r.ins);
            chk("store_we", {a_we, d_we, m_we}, {r.a, r.d, r.m});
            chk("latency", t - rise_t, r.lat);
            chk_next  = 1'b1;
            next_halt = r.hlt;
          end
        end
      end
      prev_req = imem_req; prev_addr = imem_addr; prev_ret = retire;
      prev_rst = rst; prev_halted = halted;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    errors = 0; checks = 0;
    model_pc = 16'h0000;
    rst = 1'b1; imem_ack = 1'b0; imem_rdata = '0; set_pc = 1'b0; jump_target = '0;
    a_en_in = 1'b0; d_en_in = 1'b0; m_en_in = 1'b0; halt = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("reset_req", imem_req, 0);
    chk("reset_pc", pc, 16'h0000);
    chk("reset_instr", instr, 16'h0000);
    chk("reset_retire", retire, 0);
    chk("reset_halted", halted, 0);
    chk("reset_we", {a_we, d_we, m_we}, 0);
    imem_ack = 1'b1; imem_rdata = 16'h1234;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Directed walk through the main scenarios.
    repeat (3) run_instr(0, 0);
    run_instr(3, 0);
    run_instr(0, 2);
    run_instr(0, 3);
    run_instr(0, 0);
    run_instr(1, 4);
    run_instr(0, 0);

    for (int i = 0; i < 40; i++) run_instr($urandom_range(0, 3), 1);
    run_instr(0, 0);

    // Asynchronous reset in the middle of a fetch, with ack asserted during reset.
    chk("prereset_req", imem_req, 1);
    #2 rst = 1'b0;
    #1;
    chk("async_reset_req", imem_req, 0);
    chk("async_reset_pc", pc, 16'h0000);
    imem_ack = 1'b1; imem_rdata = 16'hBEEF;
    model_pc = 16'h0000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("late_ack_ignored", instr, 16'h0000);
    chk("fetch_after_reset", imem_req, 1);
    chk("pc_after_reset", imem_addr, 16'h0000);
    @(negedge clk);
    run_instr(0, 0);
    run_instr(2, 0);
    for (int i = 0; i < 10; i++) run_instr($urandom_range(0, 3), 1);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
